// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one 8-bit-result ALU between two requesters (optional ALU_ARB_ACC_EN: op 110 accumulates on previous result)
module alu_arbiter (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Req0,
    input  logic [2:0] Op0,
    input  logic [3:0] A0,
    input  logic [3:0] B0,
    input  logic       Req1,
    input  logic [2:0] Op1,
    input  logic [3:0] A1,
    input  logic [3:0] B1,
    output logic [1:0] Grant,
    output logic       Ack0,
    output logic       Ack1,
    output logic       Busy,
    output logic [7:0] Result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t     state_q;
    logic       prio_q;
    logic       winner_q;
    logic [1:0] grant_q;
    logic       ack0_q;
    logic       ack1_q;
    logic       busy_q;
    logic [7:0] result_q;
    logic [2:0] op_q;
    logic [3:0] a_q;
    logic [3:0] b_q;

    logic       pick1_d;
    logic [7:0] alu_d;

    // Gate-level style 4-bit adder; carry-out is intentionally dropped
    function automatic logic [3:0] rca4(input logic [3:0] x, input logic [3:0] y);
        logic       c;
        logic [3:0] s;
        c = 1'b0;
        s = 4'h0;
        for (int i = 0; i < 4; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return s;
    endfunction

    // Requester 1 wins when it is alone, or when both ask and priority points at it
    always_comb begin
        pick1_d = Req1 && (!Req0 || prio_q);
    end

    // ALU over the latched opcode/operands
    always_comb begin
        alu_d = 8'h00;
        case (op_q)
            3'b000:  alu_d = {4'h0, a_q + 4'd1};
            3'b001:  alu_d = {4'h0, rca4(a_q, b_q)};
            3'b010:  alu_d = {4'h0, a_q + b_q};
            3'b011:  alu_d = {a_q | b_q, a_q ^ b_q};
            3'b100:  alu_d = {7'b0, |{a_q, b_q}};
            3'b101:  alu_d = {a_q, b_q};
`ifdef ALU_ARB_ACC_EN
            3'b110:  alu_d = {4'h0, result_q[3:0] + b_q};
`else
            3'b110:  alu_d = 8'h00;
`endif
            default: alu_d = 8'h00;
        endcase
    end

    // Transaction FSM: grant/latch, execute/ack, release/rotate priority
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            prio_q   <= 1'b0;
            winner_q <= 1'b0;
            grant_q  <= 2'b00;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= 8'h00;
            op_q     <= 3'b000;
            a_q      <= 4'h0;
            b_q      <= 4'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Req0 || Req1) begin
                        winner_q <= pick1_d;
                        op_q     <= pick1_d ? Op1 : Op0;
                        a_q      <= pick1_d ? A1 : A0;
                        b_q      <= pick1_d ? B1 : B0;
                        grant_q  <= pick1_d ? 2'b10 : 2'b01;
                        busy_q   <= 1'b1;
                        state_q  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_q <= alu_d;
                    ack0_q   <= !winner_q;
                    ack1_q   <= winner_q;
                    state_q  <= S_RESP;
                end
                S_RESP: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    grant_q <= 2'b00;
                    busy_q  <= 1'b0;
                    prio_q  <= ~winner_q;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Grant  = grant_q;
    assign Ack0   = ack0_q;
    assign Ack1   = ack1_q;
    assign Busy   = busy_q;
    assign Result = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic       Clock;
    logic       Resetn;
    logic       Req0;
    logic [2:0] Op0;
    logic [3:0] A0;
    logic [3:0] B0;
    logic       Req1;
    logic [2:0] Op1;
    logic [3:0] A1;
    logic [3:0] B1;
    logic [1:0] Grant;
    logic       Ack0;
    logic       Ack1;
    logic       Busy;
    logic [7:0] Result;

    int n_cmp = 0;
    int n_bad = 0;
    int prio  = 0;
    int prev  = 0;

    alu_arbiter dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Req0   (Req0),
        .Op0    (Op0),
        .A0     (A0),
        .B0     (B0),
        .Req1   (Req1),
        .Op1    (Op1),
        .A1     (A1),
        .B1     (B1),
        .Grant  (Grant),
        .Ack0   (Ack0),
        .Ack1   (Ack1),
        .Busy   (Busy),
        .Result (Result)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic int ref_alu(input int op, input int a, input int b, input int p);
        case (op)
            0: return (a + 1) % 16;
            1: return (a + b) % 16;
            2: return (a + b) % 16;
            3: return (a | b) * 16 + (a ^ b);
            4: return (a != 0 || b != 0) ? 1 : 0;
            5: return a * 16 + b;
`ifdef ALU_ARB_ACC_EN
            6: return ((p % 16) + b) % 16;
`else
            6: return 0;
`endif
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input int op, input int a, input int b);
        Req0 = 1'b1; Op0 = 3'(op); A0 = 4'(a); B0 = 4'(b);
    endtask

    task automatic set1(input int op, input int a, input int b);
        Req1 = 1'b1; Op1 = 3'(op); A1 = 4'(a); B1 = 4'(b);
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        Req0 = 1'b0;
        Req1 = 1'b0;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        Resetn = 1'b1;
        prio = 0;
        prev = 0;
    endtask

    // One full transaction for whichever requester the model says should win
    task automatic txn(input bit drop_early);
        int w;
        int exp;
        if (Req0 && Req1) w = prio;
        else if (Req0)    w = 0;
        else              w = 1;
        exp = (w == 0) ? ref_alu(int'(Op0), int'(A0), int'(B0), prev)
                       : ref_alu(int'(Op1), int'(A1), int'(B1), prev);
        @(posedge Clock); #1;
        chk("grant", {6'b0, Grant}, (w == 0) ? 8'd1 : 8'd2);
        chk("busy_exec", {7'b0, Busy}, 8'd1);
        chk("ack_early", {6'b0, Ack1, Ack0}, 8'd0);
        if (w == 0) begin
            Op0 = 3'($urandom); A0 = 4'($urandom); B0 = 4'($urandom);
            if (drop_early) Req0 = 1'b0;
        end else begin
            Op1 = 3'($urandom); A1 = 4'($urandom); B1 = 4'($urandom);
            if (drop_early) Req1 = 1'b0;
        end
        @(posedge Clock); #1;
        chk("ack", {6'b0, Ack1, Ack0}, (w == 0) ? 8'd1 : 8'd2);
        chk("result", Result, 8'(exp));
        chk("busy_resp", {7'b0, Busy}, 8'd1);
        if (w == 0) Req0 = 1'b0; else Req1 = 1'b0;
        @(posedge Clock); #1;
        chk("ack_clear", {6'b0, Ack1, Ack0}, 8'd0);
        chk("grant_clear", {6'b0, Grant}, 8'd0);
        chk("busy_clear", {7'b0, Busy}, 8'd0);
        prio = 1 - w;
        prev = exp;
    endtask

    task automatic chk_reset_state();
        chk("rst_grant", {6'b0, Grant}, 8'd0);
        chk("rst_ack", {6'b0, Ack1, Ack0}, 8'd0);
        chk("rst_busy", {7'b0, Busy}, 8'd0);
        chk("rst_result", Result, 8'h00);
    endtask

    initial begin
        Resetn = 1'b0;
        Req0 = 1'b0; Op0 = 3'd0; A0 = 4'd0; B0 = 4'd0;
        Req1 = 1'b0; Op1 = 3'd0; A1 = 4'd0; B1 = 4'd0;

        // Power-up reset
        do_reset();
        chk_reset_state();

        // No requests: stays idle
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock); #1;
            chk("idle_grant", {6'b0, Grant}, 8'd0);
            chk("idle_busy", {7'b0, Busy}, 8'd0);
        end

        // Simultaneous requests after reset: requester 0 first, then 1
        set0(5, 4'h3, 4'hA);
        set1(3, 4'hC, 4'h5);
        txn(1'b0);
        chk("t3_first", Result, 8'h3A);
        txn(1'b0);
        chk("t3_second", Result, 8'hD9);

        // Ripple-carry add, then behavioural add with wrap
        set0(1, 7, 5);   txn(1'b0); chk("t2_add", Result, 8'h0C);
        set0(2, 15, 1);  txn(1'b0); chk("t2_wrap", Result, 8'h00);

        // Reduction-OR, increment wrap, undefined op
        set1(4, 0, 0);   txn(1'b0); chk("t4_or0", Result, 8'h00);
        set1(4, 0, 8);   txn(1'b0); chk("t4_or1", Result, 8'h01);
        set0(0, 15, 3);  txn(1'b0); chk("t4_inc", Result, 8'h00);
        set1(7, 9, 9);   txn(1'b0); chk("t4_op7", Result, 8'h00);

        // Accumulate on previous result
        set0(1, 9, 4);   txn(1'b0); chk("t6_base", Result, 8'h0D);
        set1(6, 3, 5);   txn(1'b0);
`ifdef ALU_ARB_ACC_EN
        chk("t6_acc", Result, 8'h02);
`else
        chk("t6_acc", Result, 8'h00);
`endif

        // Request withdrawn before ack still completes
        set1(5, 2, 7);   txn(1'b1); chk("drop_early", Result, 8'h27);

        // Randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            int pat;
            pat = $urandom_range(1, 3);
            if (pat != 2) set0($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
            if (pat != 1) set1($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
            txn($urandom_range(0, 1) == 1);
            if (pat == 3) txn(1'b0);
        end

        // Reset mid-transaction
        set0(5, 1, 2);
        @(posedge Clock); #1;
        do_reset();
        chk_reset_state();

        // Reset during requester 1's EXEC: no ack, result cleared
        set0(5, 4, 4); Req0 = 1'b0;
        set1(5, 6, 6);
        @(posedge Clock); #1;
        chk("t5_grant", {6'b0, Grant}, 8'd2);
        Resetn = 1'b0;
        @(posedge Clock); #1;
        chk("t5_ack1", {7'b0, Ack1}, 8'd0);
        chk("t5_result", Result, 8'h00);
        do_reset();
        chk_reset_state();

        // Priority back at requester 0
        set0(5, 1, 1);
        set1(5, 2, 2);
        txn(1'b0); chk("t5_first", Result, 8'h11);
        txn(1'b0); chk("t5_second", Result, 8'h22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
